// File: rtl/err_event_monitor.sv
// rtl/err_event_monitor.sv - per-channel error edge monitor with first-occurrence report FIFO

// Small synchronous FIFO holding {channel, timestamp} reports.
module err_event_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             valid,
  output logic             full
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  used;
  logic [Width-1:0] mem [Depth];
  logic             do_push;
  logic             do_pop;

  // Pointer wrap that also works for depths that are not a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (used == CntW'(Depth));
  assign valid   = (used != '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  // Head is forced to zero while empty so the outputs stay stable and match reset.
  assign rdata = valid ? mem[rd_ptr] : '0;

  // Read/write pointers and occupancy; clear flushes everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   used <= used + CntW'(1);
        2'b01:   used <= used - CntW'(1);
        default: used <= used;
      endcase
    end
  end

  // Storage array; contents are only observed through valid-gated rdata.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// Watches error lines, keeps sticky flags, saturating counters and first timestamps,
// and queues one report per first occurrence.
module err_event_monitor #(
  parameter int NumChannels = 9,
  parameter int CountWidth  = 16,
  parameter int TimeWidth   = 32,
  parameter int FifoDepth   = 4,
  localparam int ChanW      = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              en_i,
  input  logic                              clear_i,
  input  logic [NumChannels-1:0]            err_i,
  output logic [NumChannels-1:0]            seen_o,
  output logic [NumChannels*CountWidth-1:0] count_o,
  output logic [TimeWidth-1:0]              cycle_o,
  output logic                              evt_valid_o,
  input  logic                              evt_ready_i,
  output logic [ChanW-1:0]                  evt_chan_o,
  output logic [TimeWidth-1:0]              evt_time_o
);

  localparam logic [CountWidth-1:0] CountMax = '1;

  logic [NumChannels-1:0] err_q;
  logic [NumChannels-1:0] seen;
  logic [NumChannels-1:0] pend;
  logic [NumChannels-1:0] occ;
  logic [NumChannels-1:0] first;
  logic [NumChannels-1:0] grant;
  logic [CountWidth-1:0]  count [NumChannels];
  logic [TimeWidth-1:0]   ts [NumChannels];
  logic [TimeWidth-1:0]   cycle;
  logic [ChanW-1:0]       grant_idx;
  logic [TimeWidth-1:0]   grant_ts;
  logic                   grant_any;
  logic                   fifo_full;
  logic                   push;
  logic [ChanW+TimeWidth-1:0] fifo_rdata;

  // Rising edge detection; clear and disable suppress occurrences but not err_q tracking.
  assign occ   = err_i & ~err_q & {NumChannels{en_i & ~clear_i}};
  assign first = occ & ~seen;

  // Previous error levels, tracked unconditionally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= '0;
    else         err_q <= err_i;
  end

  // Free-running cycle counter; wraps and is never cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cycle <= '0;
    else         cycle <= cycle + TimeWidth'(1);
  end

  // Fixed-priority arbiter over registered pending bits, lowest index wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_ts  = '0;
    grant_any = 1'b0;
    for (int e = 0; e < NumChannels; e++) begin
      if (pend[e] && !grant_any) begin
        grant_any = 1'b1;
        grant[e]  = 1'b1;
        grant_idx = ChanW'(e);
        grant_ts  = ts[e];
      end
    end
  end

  // Fullness is sampled before any pop so a slot freed this cycle is reused next cycle.
  assign push = grant_any & ~fifo_full & ~clear_i;

  // Sticky flags and pending reports; a pending channel is already seen, so set/clear never collide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seen <= '0;
      pend <= '0;
    end else if (clear_i) begin
      seen <= '0;
      pend <= '0;
    end else begin
      seen <= seen | first;
      pend <= (pend & ~(push ? grant : '0)) | first;
    end
  end

  // Saturating occurrence counters and first-occurrence timestamps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < NumChannels; e++) begin
        count[e] <= '0;
        ts[e]    <= '0;
      end
    end else if (clear_i) begin
      for (int e = 0; e < NumChannels; e++) begin
        count[e] <= '0;
        ts[e]    <= '0;
      end
    end else begin
      for (int e = 0; e < NumChannels; e++) begin
        if (occ[e] && count[e] != CountMax) count[e] <= count[e] + CountWidth'(1);
        if (first[e])                       ts[e]    <= cycle;
      end
    end
  end

  // Flatten the counter array onto the output bus.
  always_comb begin
    count_o = '0;
    for (int e = 0; e < NumChannels; e++) begin
      count_o[e*CountWidth +: CountWidth] = count[e];
    end
  end

  err_event_fifo #(
    .Width (ChanW + TimeWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (clear_i),
    .push   (push),
    .wdata  ({grant_idx, grant_ts}),
    .pop    (evt_ready_i),
    .rdata  (fifo_rdata),
    .valid  (evt_valid_o),
    .full   (fifo_full)
  );

  assign seen_o     = seen;
  assign cycle_o    = cycle;
  assign evt_chan_o = fifo_rdata[ChanW+TimeWidth-1:TimeWidth];
  assign evt_time_o = fifo_rdata[TimeWidth-1:0];

endmodule

// File: doc/err_event_monitor.md
# err_event_monitor

Parametrised, synthesisable successor to the simulation-top error-reporting logic. It watches N modulated error lines, such as the CHERI error LED drives from `sonata_system`. For each channel it keeps a sticky first-occurrence flag, a saturating occurrence counter and a first-occurrence timestamp. It queues one report per first occurrence into a FIFO with a valid/ready interface, so a DPI printer, a UART or a register block can drain the reports at its own pace.

## Interface
Parameters:
- `NumChannels`, 9: number of monitored error lines; at least 1.
- `CountWidth`, 16: width of each per-channel occurrence counter.
- `TimeWidth`, 32: width of the free-running cycle counter and of the timestamps.
- `FifoDepth`, 4: number of report FIFO entries; at least 2.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset; asynchronous, active-low.
- `en_i`, in, 1: monitoring enable. When low, occurrences are ignored.
- `clear_i`, in, 1: synchronous clear of all flags, counters, timestamps, pending bits and the FIFO.
- `err_i`, in, NumChannels: error lines, level, possibly modulated.
- `seen_o`, out, NumChannels: sticky first-occurrence flags.
- `count_o`, out, NumChannels*CountWidth: occurrence counters. Channel e occupies bits [e*CountWidth +: CountWidth].
- `cycle_o`, out, TimeWidth: free-running cycle counter.
- `evt_valid_o`, out, 1: FIFO head valid.
- `evt_ready_i`, in, 1: consumer accepts the head.
- `evt_chan_o`, out, $clog2(NumChannels) (minimum 1): channel index of the head entry.
- `evt_time_o`, out, TimeWidth: first-occurrence timestamp of the head entry.

## Operation
- `err_q` is a per-channel register of the previous `err_i` value. It is updated every cycle, including when `en_i` is low and during `clear_i`.
- An occurrence on channel e is `err_i[e] & ~err_q[e] & en_i & ~clear_i`, a rising edge sampled at a clock edge. A line held high counts once.
- On an occurrence:
  - `count[e]` increments and saturates at 2^CountWidth-1. It never wraps.
- If `seen[e]` was 0 at that occurrence:
  - set `seen[e]`;
  - set `pend[e]`;
  - capture `ts[e]` as the `cycle_o` value in the sampling cycle, i.e. the value before that edge's increment.
- Later occurrences update only the counter.
- Arbiter: each cycle, if `pend` is non-zero and the FIFO is not full at the start of the cycle, it selects the lowest-index pending channel. That channel's {e, `ts[e]`} is pushed and `pend[e]` is cleared at the same edge. At most one push per cycle.
- The arbiter considers only registered `pend`; it never looks at same-cycle occurrences.
- A pop happens on `evt_valid_o & evt_ready_i`. The head advances at that edge.
- Full FIFO: no push that cycle, even if a pop occurs. The freed slot is used from the next cycle. Pending reports wait in `pend` and are never lost.
- Empty FIFO: `evt_valid_o` is 0. `evt_chan_o` and `evt_time_o` are don't-care but stable.
- `clear_i` zeroes `seen`, `pend`, all counters and `ts`, and flushes the FIFO. `clear_i` has priority over a push, a pop and an occurrence in the same cycle. `cycle_o` is not cleared.
- `cycle_o` increments every cycle and wraps from 2^TimeWidth-1 to 0.

## Timing
- Reset values: `seen_o`=0, `count_o`=0, `cycle_o`=0, `evt_valid_o`=0, `evt_chan_o`=0, `evt_time_o`=0. Internally, `err_q`=0, `pend`=0 and the FIFO is empty.
- Consequence of the `err_q` reset value: a line already high when reset is released counts as an occurrence on the first clock edge.
- Occurrence sampled at edge T:
  - `seen_o` and `count_o` update after T;
  - the push happens at edge T+1 if the FIFO has space;
  - `evt_valid_o` rises after T+1. Latency is 2 cycles.
- K simultaneous first occurrences reach the FIFO on K consecutive edges, in ascending channel order.
- Asserting `rst_ni` mid-operation discards all state immediately, including FIFO contents and pending reports.

## Test plan
- Single event: reset, wait 5 cycles, then raise `err_i[3]` for 1 cycle. Required: `count[3]`=1, `seen_o`=9'h008, `evt_valid_o` 2 cycles later with chan=3 and time=5.
- Modulation: toggle `err_i[0]` high/low 10 times. Required: `count[0]`=10, exactly one report.
- Simultaneous events: raise `err_i[8,1,4]` in the same cycle with `evt_ready_i`=1. Required: reports 1, 4, 8 on consecutive cycles, all carrying the same timestamp.
- Backpressure: `FifoDepth`=2, `evt_ready_i`=0, first occurrences on channels 0–4. Required: the FIFO holds 0 and 1 and `pend`=5'b11100. Then raise `evt_ready_i`. Required: the remaining reports 2, 3, 4 drain in order and none are lost.
- Saturation and wrap: `CountWidth`=3 with 9 edges on a channel. Required: `count`=7. `TimeWidth`=4 run for 17 cycles. Required: `cycle_o`=1.
- Clear and enable: `clear_i` in the same cycle as an `err_i[2]` edge. Required: all outputs 0 and no report. Hold `err_i[2]` high after the clear. Required: no occurrence until it falls and rises again. With `en_i`=0, edges produce no count. Assert `rst_ni` while the FIFO holds 3 entries. Required: `evt_valid_o`=0 immediately.
